reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port general-purpose register file with HI/LO special registers, for the decode stage of the pipelined MIPS core. Replaces the fixed two-port register file. It adds synchronous reset with a hardware init sweep, registered reads with same-cycle write bypass, and a configurable number of read ports.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, index width; depth = 2**ADDR_W
- `N_RD`, 2, number of read ports (1..4)
- `SP_IDX`, 29, stack-pointer index
- `SP_INIT`, 32'h0000_3FFC, value loaded into `SP_IDX` by the init sweep
- `RA_IDX`, 31, link-register index

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rd_addr`  in  N_RD*ADDR_W  packed read indices; port p uses slice p
- `rd_data`  out  N_RD*DATA_W  packed registered read data
- `mf_sel`  in  2  00 normal, 01 port 0 returns HI, 10 port 0 returns LO, 11 reserved (treated as 00)
- `wr_en`  in  1  GPR write strobe
- `wr_addr`  in  ADDR_W  GPR write index
- `wr_data`  in  DATA_W  GPR write data
- `link_en`  in  1  jal link write to `RA_IDX`
- `link_data`  in  DATA_W  return address (PC+4)
- `hilo_we`  in  1  write HI and LO together
- `hi_wdata`, `lo_wdata`  in  DATA_W  mult/div results
- `hi`, `lo`  out  DATA_W  current HI/LO contents
- `a0`, `v0`  out  DATA_W  current contents of regs 4 and 2, used by syscall
- `ready`  out  1  high once the init sweep is complete

## Operation
- FSM states: INIT, RUN. `rst` forces INIT, clears the sweep counter `idx` to 0, clears HI/LO, and clears `rd_data`. It does this in any state, including mid-sweep.
- INIT: each cycle writes entry `idx` with 0, or with `SP_INIT` when `idx == SP_IDX`, then increments `idx`. When `idx == 2**ADDR_W-1` is written, the FSM moves to RUN. `ready` = 0 throughout INIT. All write strobes are ignored. `rd_data` holds 0.
- RUN: `ready` = 1.
- GPR write: when `wr_en` is high and `wr_addr != 0`, `wr_data` is written to `wr_addr`.
- Link write: when `link_en` is high, `link_data` is written to `RA_IDX`. If `wr_en` targets `RA_IDX` in the same cycle, the link write wins.
- Register 0 always reads 0 and is never written.
- HI/LO: when `hilo_we` is high, both are written. `hi`/`lo` outputs show the stored values.
- Read, per port p: `rd_data[p]` is registered from `rd_addr[p]`.
- Bypass: if a write to that index takes effect in the same cycle, the written value is captured instead of the stale entry. Bypass priority is link > GPR > array.
- Port 0 with `mf_sel` = 01/10 captures HI/LO. If `hilo_we` is high in the same cycle, it captures the new HI/LO.
- `a0`/`v0` are combinational from the array. They reflect writes after the edge, with no bypass.

## Timing
- Init latency: exactly 2**ADDR_W cycles after `rst` deasserts. This is 32 for the defaults, so `ready` rises on cycle 32.
- Read latency: 1 cycle, from address presented at edge n to data valid after edge n+1.
- Write-to-read: 0 cycles effective, via bypass. A write at edge n is visible on a read issued at edge n.
- No handshake on reads or writes. Upstream must hold off issue until `ready` = 1. Requests during INIT are dropped, not queued.
- Reset values: `rd_data` = 0, `hi` = `lo` = 0, `ready` = 0. `a0`/`v0` follow the array, which is 0 after the sweep. The array is undefined until swept.

## Structure
- Shared package, added to ManBearPig.h: register index constants (`zero`, `v0`, `a0`, `sp`, `ra`), `mf_sel` encodings (`move_high`, `move_low`), and the `SP_INIT` default.
- Sub-module `rf_read_port`: one read mux plus bypass compare, instantiated N_RD times in a generate loop. Port 0 gets the HI/LO override enabled via a parameter.
- The FSM, sweep counter, storage array and HI/LO registers live in the top module.

## Test plan
- Init sweep: assert `rst` 1 cycle. Then `ready` = 0 for 32 cycles and rises on cycle 32. Reading 29 gives 0x3FFC; reading 5 gives 0.
- Write then read, and bypass:
  - Write 0xDEADBEEF to reg 8 at edge n, and read reg 8 at edge n. `rd_data` port 0 = 0xDEADBEEF after edge n+1.
  - Write to reg 0. A read of reg 0 returns 0.
- Link priority: `wr_en` to reg 31 with 0x11 and `link_en` with 0x400 in the same cycle. Reg 31 reads 0x400.
- HI/LO: `hilo_we` with hi = 0x1, lo = 0x2, and `mf_sel` = 10 in the same cycle. Port 0 = 0x2, and port 1 shows its normal register.
- Reset mid-run:
  - Write reg 4 = 0x55 and check `a0` = 0x55.
  - Assert `rst`. `ready` drops next cycle, writes during INIT are ignored, and after the sweep `a0` = 0.
- N_RD = 4 build: four simultaneous reads of regs 1–4 preloaded 0xA..0xD return 0xA..0xD on their respective ports.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-read-port MIPS register file.
// Latency: n/a (constants, types and small helpers only).
// Backpressure: n/a.
//
// Contents: architectural register indices, mf_sel encodings, the default
// stack-pointer reset value and the init/run state type.
package reg_file_mp_pkg;

  // Architectural register indices used by the decode stage and syscall path.
  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  // Port 0 read-source select (mfhi / mflo). 2'b11 is reserved and reads normally.
  localparam logic [1:0] MF_NORMAL    = 2'b00;
  localparam logic [1:0] MF_MOVE_HIGH = 2'b01;
  localparam logic [1:0] MF_MOVE_LOW  = 2'b10;

  // Initial stack pointer loaded by the init sweep.
  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_3FFC;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;

  function automatic logic is_move_high(input logic [1:0] sel);
    return sel == MF_MOVE_HIGH;
  endfunction

  function automatic logic is_move_low(input logic [1:0] sel);
    return sel == MF_MOVE_LOW;
  endfunction

endpackage

// File: rtl/reg_file_mp_read_port.sv
// One registered read port with same-cycle write bypass and optional HI/LO source.
// Latency: 1 cycle (address at edge n, data valid after edge n+1).
// Backpressure: none; a new address is accepted every cycle.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (clears o_rd_data)
//   i_run                 high when the array is live; low forces o_rd_data to 0
//   i_rd_addr             register index for this port
//   i_arr_data            stored array entry at i_rd_addr (pre-write value)
//   i_mf_sel              HI/LO source select (honoured only when HILO_EN)
//   i_gpr_we/_addr/_data  effective GPR write this cycle (already gated, never reg 0)
//   i_link_we/_data       effective link write to RA_IDX this cycle
//   i_hilo_we, i_hi_wdata, i_lo_wdata, i_hi, i_lo   HI/LO write and stored values
//   o_rd_data             registered read data
module rf_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RA_IDX  = 31,
  parameter bit HILO_EN = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_arr_data,
  input  logic [1:0]        i_mf_sel,
  input  logic              i_gpr_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_link_we,
  input  logic [DATA_W-1:0] i_link_data,
  input  logic              i_hilo_we,
  input  logic [DATA_W-1:0] i_hi_wdata,
  input  logic [DATA_W-1:0] i_lo_wdata,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam logic [ADDR_W-1:0] LP_RA = ADDR_W'(RA_IDX);

  logic [1:0]        w_mf_sel;
  logic [DATA_W-1:0] w_hi_cur;
  logic [DATA_W-1:0] w_lo_cur;
  logic [DATA_W-1:0] w_gpr_val;
  logic [DATA_W-1:0] w_rd_nxt;
  logic [DATA_W-1:0] r_rd_data;

  // Ports without the HI/LO override always behave as MF_NORMAL.
  assign w_mf_sel = HILO_EN ? i_mf_sel : MF_NORMAL;

  // A same-cycle mult/div result is what mfhi/mflo must observe.
  assign w_hi_cur = i_hilo_we ? i_hi_wdata : i_hi;
  assign w_lo_cur = i_hilo_we ? i_lo_wdata : i_lo;

  // GPR value with bypass: link write beats GPR write beats the stored entry.
  always_comb begin
    w_gpr_val = i_arr_data;
    if (i_rd_addr == '0) begin
      w_gpr_val = '0;
    end else if (i_link_we && (i_rd_addr == LP_RA)) begin
      w_gpr_val = i_link_data;
    end else if (i_gpr_we && (i_rd_addr == i_wr_addr)) begin
      w_gpr_val = i_wr_data;
    end
  end

  always_comb begin
    w_rd_nxt = w_gpr_val;
    if (is_move_high(w_mf_sel)) begin
      w_rd_nxt = w_hi_cur;
    end else if (is_move_low(w_mf_sel)) begin
      w_rd_nxt = w_lo_cur;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_nxt;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/reg_file_mp.sv
// MIPS GPR file with HI/LO, N_RD registered read ports and a post-reset init sweep.
// Latency: reads 1 cycle with same-cycle write bypass; ready 2**ADDR_W cycles after reset.
// Backpressure: none; requests while o_ready is low are dropped, not queued.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rd_addr / o_rd_data   packed read indices / registered data, port p at slice p
//   i_mf_sel                port 0 source: 00 GPR, 01 HI, 10 LO, 11 GPR
//   i_wr_en/_addr/_data     GPR write (reg 0 ignored)
//   i_link_en/_data         jal link write to RA_IDX, wins over a GPR write to RA_IDX
//   i_hilo_we, i_hi_wdata, i_lo_wdata   HI/LO write together
//   o_hi, o_lo              stored HI/LO
//   o_a0, o_v0              combinational array contents of regs 4 and 2 (no bypass)
//   o_ready                 high once the init sweep has finished
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                N_RD    = 2,
  parameter int                SP_IDX  = REG_SP,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEFAULT),
  parameter int                RA_IDX  = REG_RA
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [N_RD*DATA_W-1:0]   o_rd_data,
  input  logic [1:0]               i_mf_sel,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_link_en,
  input  logic [DATA_W-1:0]        i_link_data,
  input  logic                     i_hilo_we,
  input  logic [DATA_W-1:0]        i_hi_wdata,
  input  logic [DATA_W-1:0]        i_lo_wdata,
  output logic [DATA_W-1:0]        o_hi,
  output logic [DATA_W-1:0]        o_lo,
  output logic [DATA_W-1:0]        o_a0,
  output logic [DATA_W-1:0]        o_v0,
  output logic                     o_ready
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LP_SP   = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] LP_RA   = ADDR_W'(RA_IDX);
  localparam logic [ADDR_W-1:0] LP_LAST = '1;
  localparam logic [ADDR_W-1:0] LP_A0   = ADDR_W'(REG_A0);
  localparam logic [ADDR_W-1:0] LP_V0   = ADDR_W'(REG_V0);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic              w_run;
  logic              w_sweep_we;
  logic [DATA_W-1:0] w_sweep_data;
  logic              w_gpr_we;
  logic              w_link_we;
  logic              w_hilo_we;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_idx == LP_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Reset dominates: nothing is written in a cycle where i_rst is high.
  always_comb begin
    w_run      = 1'b0;
    w_sweep_we = 1'b0;
    o_ready    = 1'b0;
    case (r_state)
      ST_INIT: w_sweep_we = !i_rst;
      ST_RUN: begin
        w_run   = !i_rst;
        o_ready = 1'b1;
      end
      default: begin
        w_run      = 1'b0;
        w_sweep_we = 1'b0;
      end
    endcase
  end

  // ---------------- sweep counter ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
    end else if (w_sweep_we) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign w_sweep_data = (r_idx == LP_SP) ? SP_INIT : '0;

  // ---------------- write strobes (dropped outside RUN) ----------------
  assign w_gpr_we  = w_run && i_wr_en && (i_wr_addr != '0);
  assign w_link_we = w_run && i_link_en;
  assign w_hilo_we = w_run && i_hilo_we;

  // ---------------- storage array ----------------
  // No reset on the array: contents become defined as the sweep visits them.
  // The link write is last so it overrides a GPR write to the same index.
  always_ff @(posedge i_clk) begin
    if (w_sweep_we) begin
      r_mem[r_idx] <= w_sweep_data;
    end
    if (w_gpr_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (w_link_we) begin
      r_mem[LP_RA] <= i_link_data;
    end
  end

  // ---------------- HI / LO ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_hilo_we) begin
      r_hi <= i_hi_wdata;
      r_lo <= i_lo_wdata;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
  assign o_a0 = r_mem[LP_A0];
  assign o_v0 = r_mem[LP_V0];

  // ---------------- read ports ----------------
  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_arr_data;

    assign w_addr     = i_rd_addr[p*ADDR_W +: ADDR_W];
    assign w_arr_data = r_mem[w_addr];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .RA_IDX  (RA_IDX),
      .HILO_EN (p == 0)
    ) u_port (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_run       (w_run),
      .i_rd_addr   (w_addr),
      .i_arr_data  (w_arr_data),
      .i_mf_sel    (i_mf_sel),
      .i_gpr_we    (w_gpr_we),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .i_link_we   (w_link_we),
      .i_link_data (i_link_data),
      .i_hilo_we   (w_hilo_we),
      .i_hi_wdata  (i_hi_wdata),
      .i_lo_wdata  (i_lo_wdata),
      .i_hi        (r_hi),
      .i_lo        (r_lo),
      .o_rd_data   (o_rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised + directed bench for reg_file_mp with a queue-based scoreboard.
// Latency: expected results are pushed at stimulus time and popped one edge later.
// Backpressure: n/a.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic                clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NR*AW-1:0]    rd_addr;
  logic [NR*DW-1:0]    rd_data;
  logic [1:0]          mf_sel;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                link_en;
  logic [DW-1:0]       link_data;
  logic                hilo_we;
  logic [DW-1:0]       hi_wdata, lo_wdata;
  logic [DW-1:0]       hi, lo, a0, v0;
  logic                ready;

  reg_file_mp #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .N_RD   (NR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .i_mf_sel    (mf_sel),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_link_en   (link_en),
    .i_link_data (link_data),
    .i_hilo_we   (hilo_we),
    .i_hi_wdata  (hi_wdata),
    .i_lo_wdata  (lo_wdata),
    .o_hi        (hi),
    .o_lo        (lo),
    .o_a0        (a0),
    .o_v0        (v0),
    .o_ready     (ready)
  );

  // Expected DUT outputs after one clock edge.
  typedef struct packed {
    logic [NR-1:0][DW-1:0] rd;
    logic [DW-1:0]         hi;
    logic [DW-1:0]         lo;
    logic [DW-1:0]         a0;
    logic [DW-1:0]         v0;
    logic                  a0_known;
    logic                  v0_known;
    logic                  ready;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: architectural register contents, HI/LO, and the
  // number of cycles left before the file becomes usable after reset.
  logic [DW-1:0] m_reg   [DEPTH];
  bit            m_known [DEPTH];
  logic [DW-1:0] m_hi, m_lo;
  int            m_swept;   // registers initialised since the last reset
  bit            m_busy;    // still initialising

  // Stimulus for the next cycle.
  bit            s_rst;
  logic [AW-1:0] s_ra [NR];
  logic [1:0]    s_mf;
  bit            s_we, s_le, s_hwe;
  logic [AW-1:0] s_wa;
  logic [DW-1:0] s_wd, s_ld, s_hw, s_lw;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    s_rst = 0; s_mf = 2'b00; s_we = 0; s_le = 0; s_hwe = 0;
    s_wa = '0; s_wd = '0; s_ld = '0; s_hw = '0; s_lw = '0;
    for (int p = 0; p < NR; p++) s_ra[p] = '0;
  endtask

  // Drive one cycle and push what the outputs must be after the next edge.
  // A read sees the register as it stands after this cycle's writes.
  task automatic apply();
    exp_t e;
    bit   was_busy;
    @(negedge clk);
    rst       = s_rst;
    for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = s_ra[p];
    mf_sel    = s_mf;
    wr_en     = s_we;   wr_addr  = s_wa; wr_data  = s_wd;
    link_en   = s_le;   link_data = s_ld;
    hilo_we   = s_hwe;  hi_wdata = s_hw; lo_wdata = s_lw;

    was_busy = m_busy;
    if (s_rst) begin
      m_busy = 1; m_swept = 0; m_hi = '0; m_lo = '0;
    end else if (m_busy) begin
      m_reg[m_swept]   = (m_swept == 29) ? 32'h0000_3FFC : 32'h0;
      m_known[m_swept] = 1;
      m_swept++;
      if (m_swept == DEPTH) m_busy = 0;
    end else begin
      if (s_we && s_wa != 0) m_reg[s_wa] = s_wd;
      if (s_le) m_reg[31] = s_ld;
      if (s_hwe) begin m_hi = s_hw; m_lo = s_lw; end
    end

    for (int p = 0; p < NR; p++) begin
      if (s_rst || was_busy)        e.rd[p] = '0;
      else if (p == 0 && s_mf == 2'b01) e.rd[p] = m_hi;
      else if (p == 0 && s_mf == 2'b10) e.rd[p] = m_lo;
      else if (s_ra[p] == 0)        e.rd[p] = '0;
      else                          e.rd[p] = m_reg[s_ra[p]];
    end
    e.hi       = m_hi;
    e.lo       = m_lo;
    e.a0       = m_reg[4];
    e.v0       = m_reg[2];
    e.a0_known = m_known[4];
    e.v0_known = m_known[2];
    e.ready    = !m_busy;
    q.push_back(e);
  endtask

  // Monitor: compares one queued expectation per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < NR; p++)
          chk($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], e.rd[p]);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("ready", {31'b0, ready}, {31'b0, e.ready});
        if (e.a0_known) chk("a0", a0, e.a0);
        if (e.v0_known) chk("v0", v0, e.v0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin clr(); apply(); end
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr(); s_we = 1; s_wa = a; s_wd = d; apply();
  endtask

  // Random strobes while the sweep is running: all must be dropped.
  task automatic noisy(input int n);
    for (int i = 0; i < n; i++) begin
      clr();
      s_we = 1; s_wa = AW'($urandom_range(0, 31)); s_wd = $urandom;
      s_le = $urandom_range(0, 1); s_ld = $urandom;
      s_hwe = $urandom_range(0, 1); s_hw = $urandom; s_lw = $urandom;
      for (int p = 0; p < NR; p++) s_ra[p] = AW'($urandom_range(0, 31));
      s_mf = 2'($urandom_range(0, 3));
      apply();
    end
  endtask

  initial begin
    rst = 1; rd_addr = '0; mf_sel = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    link_en = 0; link_data = '0; hilo_we = 0; hi_wdata = '0; lo_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin m_reg[i] = '0; m_known[i] = 0; end
    m_hi = '0; m_lo = '0; m_swept = 0; m_busy = 1;

    // Reset and init sweep; ready must rise exactly on the 32nd cycle.
    clr(); s_rst = 1; apply();
    noisy(32);

    // Sweep values: SP holds the initial stack pointer, others are zero.
    clr(); s_ra[0] = 29; s_ra[1] = 5; s_ra[2] = 0; s_ra[3] = 31; apply();

    // Same-cycle write/read bypass.
    clr(); s_we = 1; s_wa = 8; s_wd = 32'hDEAD_BEEF; s_ra[0] = 8; s_ra[1] = 8; apply();
    clr(); s_ra[2] = 8; apply();

    // Writes to reg 0 are discarded.
    clr(); s_we = 1; s_wa = 0; s_wd = 32'h1234_5678; s_ra[0] = 0; apply();
    clr(); s_ra[1] = 0; apply();

    // Link beats GPR write to RA.
    clr(); s_we = 1; s_wa = 31; s_wd = 32'h11; s_le = 1; s_ld = 32'h400;
    s_ra[0] = 31; s_ra[3] = 31; apply();
    clr(); s_ra[1] = 31; apply();

    // HI/LO write with mflo / mfhi / reserved select in the same cycle.
    clr(); s_hwe = 1; s_hw = 32'h1; s_lw = 32'h2; s_mf = 2'b10; s_ra[0] = 8; s_ra[1] = 8; apply();
    clr(); s_hwe = 1; s_hw = 32'h33; s_lw = 32'h44; s_mf = 2'b01; s_ra[1] = 31; apply();
    clr(); s_mf = 2'b11; s_ra[0] = 8; apply();

    // a0 / v0 follow the array.
    write(4, 32'h55);
    write(2, 32'h77);

    // Reset mid-run, strobes ignored, then a reset mid-sweep.
    clr(); s_rst = 1; apply();
    noisy(10);
    clr(); s_rst = 1; apply();
    noisy(32);
    idle(1);

    // Four simultaneous reads of preloaded regs 1..4.
    write(1, 32'hA); write(2, 32'hB); write(3, 32'hC); write(4, 32'hD);
    clr(); for (int p = 0; p < NR; p++) s_ra[p] = AW'(p + 1); apply();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      clr();
      s_rst = ($urandom_range(0, 249) == 0);
      for (int p = 0; p < NR; p++) s_ra[p] = AW'($urandom_range(0, 31));
      s_mf  = 2'($urandom_range(0, 3));
      s_we  = $urandom_range(0, 1);
      s_wa  = ($urandom_range(0, 1) == 0) ? s_ra[$urandom_range(0, NR-1)] : AW'($urandom_range(0, 31));
      s_wd  = $urandom;
      s_le  = ($urandom_range(0, 3) == 0);
      s_ld  = $urandom;
      if ($urandom_range(0, 3) == 0) s_ra[$urandom_range(0, NR-1)] = 31;
      s_hwe = ($urandom_range(0, 3) == 0);
      s_hw  = $urandom;
      s_lw  = $urandom;
      apply();
    end

    // Drain and confirm every expectation was consumed.
    idle(1);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", DW'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
